// File: rtl/VX_tensor_pkg.sv
// Shared types and constants for the tensor-unit CSR driver and the tensor unit.
// Holds the driver state encoding and the operand buffer select codes.
package VX_tensor_pkg;

   localparam int TENSOR_NUM_WORDS = 4;

   // Buffer select codes carried on csr_wr_sel
   localparam logic TENSOR_SEL_A = 1'b0;
   localparam logic TENSOR_SEL_B = 1'b1;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      START      = 3'd1,
      LOAD       = 3'd2,
      WAIT_LOAD  = 3'd3,
      WAIT_EXEC  = 3'd4,
      WAIT_STORE = 3'd5,
      STORE      = 3'd6
   } tensor_drv_state_t;

   // States in which the driver is blocked on the tensor unit and must be guarded
   function automatic logic tensor_drv_watched(input tensor_drv_state_t s);
      return (s == WAIT_LOAD) || (s == WAIT_EXEC) || (s == WAIT_STORE) || (s == STORE);
   endfunction

endpackage

// File: rtl/VX_tensor_watchdog.sv
// Cycle counter that flags expiry after TIMEOUT_CYCLES-1 enabled cycles.
// Restarts from zero on clear or whenever it is disabled.
module VX_tensor_watchdog #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_reg <= '0;
      end else if (clear || !enable) begin
         count_reg <= '0;
      end else if (count_reg != LIMIT) begin
         count_reg <= count_reg + CW'(1);
      end
   end

   assign expired = enable && (count_reg == LIMIT);

endmodule

// File: rtl/vx_tensor_csr_driver.sv
// CSR-side initiator for the tensor unit: stages A/B, streams operands, collects C
// and sequences load/execute/store with sticky early-event capture and a watchdog.
module vx_tensor_csr_driver
   import VX_tensor_pkg::*;
#(
   parameter int NUM_WORDS      = TENSOR_NUM_WORDS,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 1024,
   localparam int IW            = $clog2(NUM_WORDS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  csr_wr_en,
   input  logic                  csr_wr_sel,
   input  logic [IW-1:0]         csr_wr_idx,
   input  logic [DATA_WIDTH-1:0] csr_wr_data,
   input  logic                  csr_start,
   input  logic [IW-1:0]         csr_rd_idx,
   output logic [DATA_WIDTH-1:0] csr_rd_data,
   output logic                  busy,
   output logic                  done,
   output logic                  timeout,
   output logic                  tensor_load_start,
   output logic [DATA_WIDTH-1:0] data_out_a,
   output logic [DATA_WIDTH-1:0] data_out_b,
   output logic                  data_out_valid,
   input  logic                  tensor_load_done,
   input  logic                  tensor_execute_done,
   input  logic                  tensor_store_start,
   input  logic                  tensor_store_done,
   input  logic [DATA_WIDTH-1:0] data_in_c,
   input  logic                  data_in_c_valid
);

   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

   tensor_drv_state_t state_reg, state_next;
   logic [IW-1:0]     idx_reg, idx_next;

   logic [DATA_WIDTH-1:0] a_mem [NUM_WORDS];
   logic [DATA_WIDTH-1:0] b_mem [NUM_WORDS];
   logic [DATA_WIDTH-1:0] c_mem [NUM_WORDS];
   logic [NUM_WORDS-1:0]  a_we, b_we, c_we_vec;

   logic busy_w, stage_we, accept_start, c_we, set_done, set_timeout;
   logic load_seen_reg, exec_seen_reg, sstart_seen_reg;
   logic wd_clear, wd_enable, wd_expired;

   logic                  busy_reg, done_reg, timeout_reg, load_start_reg, valid_reg;
   logic [DATA_WIDTH-1:0] data_out_a_reg, data_out_b_reg;

   assign busy_w       = (state_reg != IDLE);
   assign stage_we     = csr_wr_en && !busy_w;
   assign accept_start = (state_reg == IDLE) && csr_start;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_we
         assign a_we[gi]     = stage_we && (csr_wr_sel == TENSOR_SEL_A) && (csr_wr_idx == IW'(gi));
         assign b_we[gi]     = stage_we && (csr_wr_sel == TENSOR_SEL_B) && (csr_wr_idx == IW'(gi));
         assign c_we_vec[gi] = c_we && (idx_reg == IW'(gi));
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            a_mem[i] <= '0;
            b_mem[i] <= '0;
            c_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if (a_we[i])     a_mem[i] <= csr_wr_data;
            if (b_we[i])     b_mem[i] <= csr_wr_data;
            if (c_we_vec[i]) c_mem[i] <= data_in_c;
         end
      end
   end

   assign csr_rd_data = c_mem[csr_rd_idx];

   VX_tensor_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .clear   (wd_clear),
      .enable  (wd_enable),
      .expired (wd_expired)
   );

   assign wd_enable = tensor_drv_watched(state_reg);
   assign wd_clear  = (state_next != state_reg);

   always_comb begin
      state_next  = state_reg;
      idx_next    = idx_reg;
      c_we        = 1'b0;
      set_done    = 1'b0;
      set_timeout = 1'b0;
      case (state_reg)
         IDLE: begin
            if (csr_start) begin
               state_next = START;
               idx_next   = '0;
            end
         end
         START: state_next = LOAD;
         LOAD: begin
            if (idx_reg == LAST_IDX) begin
               idx_next   = '0;
               state_next = WAIT_LOAD;
            end else begin
               idx_next = idx_reg + IW'(1);
            end
         end
         WAIT_LOAD: begin
            if (tensor_load_done || load_seen_reg) begin
               state_next = WAIT_EXEC;
            end else if (wd_expired) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         WAIT_EXEC: begin
            if (tensor_execute_done || exec_seen_reg) begin
               state_next = WAIT_STORE;
            end else if (wd_expired) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         WAIT_STORE: begin
            if (tensor_store_start || sstart_seen_reg) begin
               state_next = STORE;
               idx_next   = '0;
            end else if (wd_expired) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         STORE: begin
            // A beat coincident with store_done is still written before completing
            if (data_in_c_valid) begin
               c_we = 1'b1;
               if (idx_reg != LAST_IDX) idx_next = idx_reg + IW'(1);
            end
            if (tensor_store_done) begin
               state_next = IDLE;
               set_done   = 1'b1;
            end else if (wd_expired) begin
               state_next  = IDLE;
               set_timeout = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs are registered from the next-state values so they line up with the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg       <= IDLE;
         idx_reg         <= '0;
         load_seen_reg   <= 1'b0;
         exec_seen_reg   <= 1'b0;
         sstart_seen_reg <= 1'b0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         timeout_reg     <= 1'b0;
         load_start_reg  <= 1'b0;
         valid_reg       <= 1'b0;
         data_out_a_reg  <= '0;
         data_out_b_reg  <= '0;
      end else begin
         state_reg      <= state_next;
         idx_reg        <= idx_next;
         busy_reg       <= (state_next != IDLE);
         load_start_reg <= (state_next == START);
         valid_reg      <= (state_next == LOAD);
         data_out_a_reg <= (state_next == LOAD) ? a_mem[idx_next] : '0;
         data_out_b_reg <= (state_next == LOAD) ? b_mem[idx_next] : '0;
         if (accept_start) begin
            done_reg        <= 1'b0;
            timeout_reg     <= 1'b0;
            load_seen_reg   <= 1'b0;
            exec_seen_reg   <= 1'b0;
            sstart_seen_reg <= 1'b0;
         end else begin
            if (set_done)    done_reg    <= 1'b1;
            if (set_timeout) timeout_reg <= 1'b1;
            if (busy_w && tensor_load_done)    load_seen_reg   <= 1'b1;
            if (busy_w && tensor_execute_done) exec_seen_reg   <= 1'b1;
            if (busy_w && tensor_store_start)  sstart_seen_reg <= 1'b1;
         end
      end
   end

   assign busy              = busy_reg;
   assign done              = done_reg;
   assign timeout           = timeout_reg;
   assign tensor_load_start = load_start_reg;
   assign data_out_valid    = valid_reg;
   assign data_out_a        = data_out_a_reg;
   assign data_out_b        = data_out_b_reg;

endmodule

// File: tb/tb_vx_tensor_csr_driver.sv
// Scoreboard bench for vx_tensor_csr_driver: operand beats are checked by a monitor
// against a queue filled at start time; status and C reads are checked in line.
module tb_vx_tensor_csr_driver;
   import VX_tensor_pkg::*;

   localparam int NW = 4;
   localparam int DW = 32;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          csr_wr_en = 1'b0, csr_wr_sel = 1'b0, csr_start = 1'b0;
   logic [1:0]    csr_wr_idx = '0, csr_rd_idx = '0;
   logic [DW-1:0] csr_wr_data = '0, csr_rd_data;
   logic          busy, done, timeout, tensor_load_start, data_out_valid;
   logic [DW-1:0] data_out_a, data_out_b;
   logic          tensor_load_done = 1'b0, tensor_execute_done = 1'b0;
   logic          tensor_store_start = 1'b0, tensor_store_done = 1'b0;
   logic [DW-1:0] data_in_c = '0;
   logic          data_in_c_valid = 1'b0;

   always #5 clk = ~clk;

   vx_tensor_csr_driver #(
      .NUM_WORDS      (NW),
      .DATA_WIDTH     (DW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                 (clk),
      .reset               (reset),
      .csr_wr_en           (csr_wr_en),
      .csr_wr_sel          (csr_wr_sel),
      .csr_wr_idx          (csr_wr_idx),
      .csr_wr_data         (csr_wr_data),
      .csr_start           (csr_start),
      .csr_rd_idx          (csr_rd_idx),
      .csr_rd_data         (csr_rd_data),
      .busy                (busy),
      .done                (done),
      .timeout             (timeout),
      .tensor_load_start   (tensor_load_start),
      .data_out_a          (data_out_a),
      .data_out_b          (data_out_b),
      .data_out_valid      (data_out_valid),
      .tensor_load_done    (tensor_load_done),
      .tensor_execute_done (tensor_execute_done),
      .tensor_store_start  (tensor_store_start),
      .tensor_store_done   (tensor_store_done),
      .data_in_c           (data_in_c),
      .data_in_c_valid     (data_in_c_valid)
   );

   typedef struct packed {
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } beat_t;

   beat_t         exp_q[$];
   logic [DW-1:0] a_m [NW];
   logic [DW-1:0] b_m [NW];
   logic [DW-1:0] c_m [NW];
   int            errors = 0;
   int            checks = 0;
   int            pulses = 0;
   int            wl_cnt = 0;
   int            we_cnt = 0;

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic monitor();
      beat_t e;
      forever begin
         @(negedge clk);
         if (tensor_load_start) pulses++;
         if (dut.state_reg == WAIT_LOAD) wl_cnt++;
         if (dut.state_reg == WAIT_EXEC) we_cnt++;
         if (data_out_valid) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL beat_unexpected: actual a=%0h b=%0h required no beat", data_out_a, data_out_b);
            end else begin
               e = exp_q.pop_front();
               check("beat_a", data_out_a, e.a);
               check("beat_b", data_out_b, e.b);
            end
         end
      end
   endtask

   task automatic csr_write(input logic sel, input int idx, input logic [DW-1:0] d);
      csr_wr_en   = 1'b1;
      csr_wr_sel  = sel;
      csr_wr_idx  = 2'(idx);
      csr_wr_data = d;
      tick();
      csr_wr_en = 1'b0;
      if (sel) b_m[idx] = d;
      else     a_m[idx] = d;
   endtask

   task automatic start_run();
      beat_t e;
      for (int i = 0; i < NW; i++) begin
         e.a = a_m[i];
         e.b = b_m[i];
         exp_q.push_back(e);
      end
      csr_start = 1'b1;
      tick();
      csr_start = 1'b0;
   endtask

   task automatic respond(input bit early, input int nbeats, input logic [DW-1:0] base, input bit concurrent);
      int wi;
      if (!early) begin
         tensor_load_done = 1'b1;
         tick();
         tensor_load_done = 1'b0;
         tensor_execute_done = 1'b1;
         tick();
         tensor_execute_done = 1'b0;
      end
      tensor_store_start = 1'b1;
      tick();
      tensor_store_start = 1'b0;
      wi = 0;
      for (int i = 0; i < nbeats; i++) begin
         data_in_c       = base + DW'(i);
         data_in_c_valid = 1'b1;
         c_m[wi]         = base + DW'(i);
         if (wi < NW - 1) wi++;
         if (concurrent && i == nbeats - 1) begin
            tensor_store_done = 1'b1;
            @(negedge clk);
            check("done_before_end", done, 1'b0);
         end
         tick();
      end
      data_in_c_valid = 1'b0;
      data_in_c       = '0;
      if (!concurrent) begin
         tensor_store_done = 1'b1;
         @(negedge clk);
         check("done_before_end", done, 1'b0);
         tick();
      end
      tensor_store_done = 1'b0;
      @(negedge clk);
      check("done", done, 1'b1);
      check("busy_end", busy, 1'b0);
      check("timeout_clear", timeout, 1'b0);
      for (int i = 0; i < NW; i++) begin
         csr_rd_idx = 2'(i);
         #1;
         check($sformatf("c_read%0d", i), csr_rd_data, c_m[i]);
      end
   endtask

   initial begin
      int wl0, we0, lat;
      fork
         monitor();
      join_none
      for (int i = 0; i < NW; i++) begin
         a_m[i] = '0;
         b_m[i] = '0;
         c_m[i] = '0;
      end

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      check("rst_load_start", tensor_load_start, 1'b0);
      check("rst_valid", data_out_valid, 1'b0);
      check("rst_rd_data", csr_rd_data, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      // Nominal run with a write and a restart attempted mid-LOAD
      for (int i = 0; i < NW; i++) begin
         csr_write(1'b0, i, DW'(i + 1));
         csr_write(1'b1, i, DW'(i + 5));
      end
      start_run();
      tick();
      csr_wr_en   = 1'b1;
      csr_wr_sel  = 1'b0;
      csr_wr_idx  = 2'd0;
      csr_wr_data = 32'hDEAD;
      csr_start   = 1'b1;
      tick();
      csr_wr_en = 1'b0;
      csr_start = 1'b0;
      repeat (3) tick();
      respond(1'b0, 4, 32'd9, 1'b0);
      check("pulses_after_nominal", pulses, 1);

      // Early load_done + execute_done during the second LOAD beat; A[0] must still be 1
      wl0 = wl_cnt;
      we0 = we_cnt;
      start_run();
      tick();
      tick();
      tensor_load_done    = 1'b1;
      tensor_execute_done = 1'b1;
      tick();
      tensor_load_done    = 1'b0;
      tensor_execute_done = 1'b0;
      repeat (4) tick();
      respond(1'b1, 4, 32'h21, 1'b0);
      check("wait_load_cycles", wl_cnt - wl0, 1);
      check("wait_exec_cycles", we_cnt - we0, 1);

      // Watchdog expiry in WAIT_EXEC
      start_run();
      repeat (NW + 1) tick();
      tensor_load_done = 1'b1;
      tick();
      tensor_load_done = 1'b0;
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         tick();
         @(negedge clk);
         if (!busy) begin
            lat = n;
            break;
         end
      end
      check("timeout_latency", lat, TO);
      check("timeout_set", timeout, 1'b1);
      check("timeout_done", done, 1'b0);
      start_run();
      @(negedge clk);
      check("timeout_cleared_by_start", timeout, 1'b0);
      repeat (NW + 1) tick();
      respond(1'b0, 4, 32'h41, 1'b0);

      // Five C beats, last one together with store_done
      start_run();
      repeat (NW + 1) tick();
      respond(1'b0, 5, 32'h31, 1'b1);

      // Asynchronous reset during a LOAD beat
      start_run();
      repeat (3) tick();
      reset = 1'b1;
      exp_q.delete();
      #1;
      check("arst_busy", busy, 1'b0);
      check("arst_valid", data_out_valid, 1'b0);
      check("arst_a", data_out_a, '0);
      check("arst_b", data_out_b, '0);
      check("arst_load_start", tensor_load_start, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_state", 32'(dut.state_reg), 32'(IDLE));
      for (int i = 0; i < NW; i++) begin
         csr_rd_idx = 2'(i);
         #1;
         check($sformatf("arst_c%0d", i), csr_rd_data, '0);
         a_m[i] = '0;
         b_m[i] = '0;
         c_m[i] = '0;
      end
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      start_run();
      repeat (NW + 1) tick();
      respond(1'b0, 4, 32'h51, 1'b0);

      check("beats_outstanding", exp_q.size(), 0);
      check("pulses_total", pulses, 7);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
